l1_arbiter: RTL and testbench
=============================

// Module: l1_arbiter
// PURPOSE
//  Shares the single-port L1 cache (64 x 32-bit) between two requesters:
//   port A: instruction fetch, read-only; port B: load/store unit, read/write.
//  Sequences each access: arbitrate, issue one mem_en cycle, wait for mem_ready, return data/ack.
//  Only one access is in flight at a time. Sits between the core front end / LSU and l1_cache.
// PARAMETERS
//  AW       16  address width (all ports)
//  DW       32  data width
//  TIMEOUT  15  max WAIT cycles before error ack (1..255; counter is 8 bits)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   async reset, active-low
//  a_req      in   1   fetch request; held until a_ack
//  a_addr     in   AW  fetch address
//  a_ack      out  1   1-cycle pulse: a_rdata valid
//  a_rdata    out  DW  fetch read data
//  a_err      out  1   valid with a_ack: timeout, data = 0
//  b_req      in   1   LSU request; held until b_ack
//  b_we       in   1   1 = write, 0 = read
//  b_addr     in   AW  LSU address
//  b_wdata    in   DW  LSU write data
//  b_ack      out  1   1-cycle pulse: b access complete
//  b_rdata    out  DW  LSU read data (unchanged on write)
//  b_err      out  1   valid with b_ack: timeout
//  mem_en     out  1   to cache clk_en; high exactly 1 cycle per access
//  mem_we     out  1   write strobe, qualified by mem_en
//  mem_addr   out  AW  cache address
//  mem_wdata  out  DW  cache write data
//  mem_rdata  in   DW  cache read_data
//  mem_ready  in   1   cache data_ready
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; rr pointer=A; timeout counter=0. Reset mid-access drops it, no ack.
//  FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, all registered:
//   IDLE : if a_req|b_req, pick winner; latch addr/we/wdata and owner -> ISSUE. Else stay.
//   ISSUE: mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched. Counter cleared. -> WAIT.
//   WAIT : mem_en=0. If mem_ready=1, capture mem_rdata -> DONE. Else count++.
//          Count reaches TIMEOUT -> DONE with err=1, data=0.
//   DONE : owner's ack=1 for exactly this cycle, rdata/err valid, other port's ack=0 -> IDLE.
//  Latency: req seen in IDLE at cycle N -> mem_en at N+1 -> ack at N+3 if mem_ready at N+2.
//  mem_ready is sampled only in WAIT; level stuck high from a prior access is
//   accepted: cache updates read_data on the same edge as data_ready.
//  Requester holds req/addr/wdata until ack; arbiter uses latched copies, so mid-access changes are ignored.
//  After ack, requester drops req or presents the next access. A req still high at IDLE is a new request.
//  Minimum spacing of back-to-back accesses: 4 cycles.
//  rdata holds last value between acks. Writes: b_rdata unchanged, b_err still reported.
//  Address passes through unchanged: AW bits. Cache decodes low 6 bits. No range check.
// CONFIGURATION
//  L1_ARB_ROUND_ROBIN_EN defined: a_req and b_req both high in IDLE -> grant the port NOT granted last.
//   rr pointer updates on every grant. A lone request is granted immediately.
//  Undefined: fixed priority, A (fetch) always wins ties. B can starve under continuous fetch. No rr pointer.
// TESTING
//  1. Reset: rst low for 3 clk -> all outputs 0, busy=0. Release with no req -> mem_en stays 0.
//  2. a_req, a_addr=0x000A, mem_ready high at N+2 with rdata=0xDEADBEEF
//     -> mem_en at N+1 only, a_ack at N+3, a_rdata=0xDEADBEEF.
//  3. b_req, b_we=1, b_addr=0x0005, b_wdata=0x12345678
//     -> one cycle with mem_en=mem_we=1, mem_addr=5, mem_wdata=0x12345678, then b_ack, b_err=0.
//  4. a_req and b_req held high for 4 accesses
//     -> RR_EN: grant order A,B,A,B. Without macro: A,A,A,A.
//  5. mem_ready held 0 after ISSUE -> ack exactly TIMEOUT+1 cycles after mem_en, err=1, rdata=0, FSM back to IDLE.
//  6. rst low during WAIT -> no ack, mem_en=0. After release a new a_req completes normally.

Source files
------------

// File: rtl/l1_arbiter_if.sv
// Bundles the fetch port, the LSU port and the cache-side bus of the L1 arbiter.
// Latency: none, wires only.
// Backpressure: req/ack handshake on A and B; mem_en/mem_ready toward the cache.
// Ports: a_* fetch (read-only), b_* load/store, mem_* cache side, busy status.
// Modports: master = arbiter view, slave = requesters + cache view.
interface l1_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          a_req;
  logic [AW-1:0] a_addr;
  logic          a_ack;
  logic [DW-1:0] a_rdata;
  logic          a_err;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic [DW-1:0] b_rdata;
  logic          b_err;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          busy;

  modport master (
    input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_rdata, mem_ready,
    output a_ack, a_rdata, a_err, b_ack, b_rdata, b_err,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    output a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_rdata, mem_ready,
    input  a_ack, a_rdata, a_err, b_ack, b_rdata, b_err,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/l1_arbiter.sv
// Shares the single-port L1 cache between instruction fetch (A) and the LSU (B).
// Latency: req seen in IDLE at N -> mem_en at N+1 -> ack at N+3 with mem_ready at N+2.
// Backpressure: requesters hold req until ack; one access in flight, TIMEOUT bounds WAIT.
// Ports: clk, rst (async, active-low), bus (l1_arbiter_if.master: a_*, b_*, mem_*, busy).
// Macro L1_ARB_ROUND_ROBIN_EN: ties go to the port not granted last; default is
// fixed priority with fetch (A) winning every tie.
module l1_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  l1_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // WAIT lasts TIMEOUT cycles at most, so the last count value is TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       owner_b;   // 1: access belongs to port B
  logic       we_q;      // latched write flag of the access in flight
  logic [7:0] cnt;
  logic       grant_b;

`ifdef L1_ARB_ROUND_ROBIN_EN
  logic rr_prio_b;  // 1: B wins the next tie

  always_comb grant_b = bus.b_req & (~bus.a_req | rr_prio_b);
`else
  always_comb grant_b = bus.b_req & ~bus.a_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner_b       <= 1'b0;
      we_q          <= 1'b0;
      cnt           <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.a_ack     <= 1'b0;
      bus.a_rdata   <= '0;
      bus.a_err     <= 1'b0;
      bus.b_ack     <= 1'b0;
      bus.b_rdata   <= '0;
      bus.b_err     <= 1'b0;
      bus.busy      <= 1'b0;
`ifdef L1_ARB_ROUND_ROBIN_EN
      rr_prio_b     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.a_req | bus.b_req) begin
            // mem_addr/mem_wdata double as the latched request copies, so
            // later changes on the requester side cannot disturb the access.
            owner_b       <= grant_b;
            we_q          <= grant_b & bus.b_we;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= grant_b & bus.b_we;
            bus.mem_addr  <= grant_b ? bus.b_addr : bus.a_addr;
            bus.mem_wdata <= grant_b ? bus.b_wdata : '0;
            cnt           <= '0;
            bus.busy      <= 1'b1;
            state         <= ISSUE;
`ifdef L1_ARB_ROUND_ROBIN_EN
            rr_prio_b     <= ~grant_b;
`endif
          end
        end

        ISSUE: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          cnt        <= '0;
          state      <= WAIT;
        end

        WAIT: begin
          if (bus.mem_ready) begin
            state <= DONE;
            if (owner_b) begin
              bus.b_ack <= 1'b1;
              bus.b_err <= 1'b0;
              if (!we_q) bus.b_rdata <= bus.mem_rdata;
            end else begin
              bus.a_ack   <= 1'b1;
              bus.a_err   <= 1'b0;
              bus.a_rdata <= bus.mem_rdata;
            end
          end else if (cnt == CNT_LAST) begin
            // Timeout: error ack with zero data; a write keeps b_rdata.
            state <= DONE;
            if (owner_b) begin
              bus.b_ack <= 1'b1;
              bus.b_err <= 1'b1;
              if (!we_q) bus.b_rdata <= '0;
            end else begin
              bus.a_ack   <= 1'b1;
              bus.a_err   <= 1'b1;
              bus.a_rdata <= '0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        DONE: begin
          bus.a_ack <= 1'b0;
          bus.a_err <= 1'b0;
          bus.b_ack <= 1'b0;
          bus.b_err <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_arbiter.sv
// Scoreboard bench for l1_arbiter: expected issues/acks queued at drive time.
// Latency: checked per access from mem_en to ack.
// Backpressure: a simple cache model answers mem_en one cycle later unless stalled.
module tb_l1_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 15;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } iss_t;

  typedef struct {
    logic          port;   // 0 = A, 1 = B
    logic [DW-1:0] data;
    logic          err;
    int            lat;
  } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;

  always #5 clk = ~clk;

  l1_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  l1_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cyc = 0;
  int en_count = 0;
  logic prev_en = 1'b0;
  logic [DW-1:0] b_shadow = '0;

  iss_t iss_q[$];
  ack_t ack_q[$];
  logic [DW-1:0] mem [64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_mem(input logic [5:0] a);
    return (a == 6'd10) ? 32'hDEADBEEF : {24'hC0FFEE, 2'b00, a};
  endfunction

  // Cache model: answers each mem_en with data_ready one cycle later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= exp_mem(6'(i));
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
    end else if (bus.mem_en && !stall) begin
      bus.mem_ready <= 1'b1;
      bus.mem_rdata <= mem[bus.mem_addr[5:0]];
      if (bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end else begin
      bus.mem_ready <= 1'b0;
    end
  end

  // Monitor: compares issues and acks against the scoreboard queues.
  always @(negedge clk) begin
    iss_t ei;
    ack_t ea;
    cyc++;
    if (rst) begin
      if (bus.mem_en) begin
        en_count++;
        chk("en_1cyc", prev_en, 0);
        en_cyc = cyc;
        if (iss_q.size() == 0) chk("unexp_issue", 1, 0);
        else begin
          ei = iss_q.pop_front();
          chk("mem_addr", bus.mem_addr, ei.addr);
          chk("mem_we", bus.mem_we, ei.we);
          if (ei.we) chk("mem_wdata", bus.mem_wdata, ei.wdata);
        end
      end
      if (bus.a_ack || bus.b_ack) begin
        chk("ack_excl", bus.a_ack & bus.b_ack, 0);
        if (ack_q.size() == 0) chk("unexp_ack", 1, 0);
        else begin
          ea = ack_q.pop_front();
          chk("ack_port", bus.b_ack, ea.port);
          chk("latency", cyc - en_cyc, ea.lat);
          if (ea.port) begin
            chk("b_rdata", bus.b_rdata, ea.data);
            chk("b_err", bus.b_err, ea.err);
          end else begin
            chk("a_rdata", bus.a_rdata, ea.data);
            chk("a_err", bus.a_err, ea.err);
          end
        end
      end
    end
    prev_en = bus.mem_en;
  end

  task automatic wait_ack(input logic port, input int bound, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (port ? bus.b_ack : bus.a_ack) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic rd_a(input logic [AW-1:0] addr, input logic [DW-1:0] d,
                      input logic err, input int lat);
    logic seen;
    iss_q.push_back('{addr, 1'b0, '0});
    ack_q.push_back('{1'b0, d, err, lat});
    bus.a_addr = addr;
    bus.a_req  = 1'b1;
    wait_ack(1'b0, 200, seen);
    bus.a_req  = 1'b0;
    chk("a_done", seen, 1);
  endtask

  task automatic acc_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic err, input int lat);
    logic seen;
    logic [DW-1:0] d;
    d = we ? b_shadow : (err ? '0 : exp_mem(addr[5:0]));
    b_shadow = d;
    iss_q.push_back('{addr, we, wd});
    ack_q.push_back('{1'b1, d, err, lat});
    bus.b_we    = we;
    bus.b_addr  = addr;
    bus.b_wdata = wd;
    bus.b_req   = 1'b1;
    wait_ack(1'b1, 200, seen);
    bus.b_req   = 1'b0;
    chk("b_done", seen, 1);
  endtask

  initial begin
    logic seen;
    logic order [4];
    int n;

    bus.a_req = 1'b0; bus.a_addr = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    // 1. reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    chk("rst_a", {bus.a_ack, bus.a_err, bus.a_rdata}, 0);
    chk("rst_b", {bus.b_ack, bus.b_err, bus.b_rdata}, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_en", en_count, 0);
    chk("idle_busy", bus.busy, 0);

    // 2. fetch read
    rd_a(16'h000A, 32'hDEADBEEF, 1'b0, 2);

    // 3. LSU write, then read-back through B
    acc_b(1'b1, 16'h0005, 32'h12345678, 1'b0, 2);
    chk("a_rdata_hold", bus.a_rdata, 32'hDEADBEEF);
    chk("b_rdata_wr", bus.b_rdata, 0);
    acc_b(1'b0, 16'h0007, '0, 1'b0, 2);

    // 4. both requesting continuously for four accesses
`ifdef L1_ARB_ROUND_ROBIN_EN
    order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      iss_q.push_back('{order[i] ? 16'h0021 : 16'h0010, 1'b0, '0});
      ack_q.push_back('{order[i], exp_mem(order[i] ? 6'h21 : 6'h10), 1'b0, 2});
    end
    bus.a_addr = 16'h0010;
    bus.b_addr = 16'h0021;
    bus.b_we   = 1'b0;
    bus.a_req  = 1'b1;
    bus.b_req  = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.a_ack || bus.b_ack) n++;
      if (n == 4) break;
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    chk("t4_acks", n, 4);
    repeat (4) @(negedge clk);
    chk("t4_drained", ack_q.size(), 0);

    // 5. timeout
    stall = 1'b1;
    rd_a(16'h000A, 32'h0, 1'b1, TO + 1);
    stall = 1'b0;
    @(negedge clk);
    chk("t5_idle", bus.busy, 0);

    // 6. reset during WAIT
    stall = 1'b1;
    iss_q.push_back('{16'h0003, 1'b0, '0});
    bus.a_addr = 16'h0003;
    bus.a_req  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_issued", seen, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.a_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_no_ack", bus.a_ack, 0);
      chk("t6_no_en", bus.mem_en, 0);
    end
    chk("t6_busy", bus.busy, 0);
    rst = 1'b1;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    rd_a(16'h000A, 32'hDEADBEEF, 1'b0, 2);

    repeat (5) @(negedge clk);
    chk("queues_empty", ack_q.size() + iss_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
